// File: rtl/adder_self_test.sv
// adder_self_test
//
// On-chip stimulus generator and checker for a 3-input full adder
// (switch_0..2 -> led_0 sum, led_1 carry). The block takes the place of the
// board switches. It walks the eight input patterns in binary order and holds
// each one for STEP_CYCLES clocks. On the last cycle of each step it compares
// the registered LED value against the expected sum and carry. It then
// reports per-pattern errors, an error count and an overall pass flag.
//
// Parameters:
//   STEP_CYCLES  clocks each pattern is held on the stim outputs (>= 3)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous reset, active-high
//   start       begins a run when sampled high in idle or done
//   stim_0..2   adder switch drives, pattern bits 0 (LSB) .. 2
//   led_0       adder sum output under test
//   led_1       adder carry output under test
//   busy        high while a run is in progress
//   done        high from run completion until the next start or reset
//   pass        valid with done; 1 when no pattern mismatched
//   err_count   number of mismatching patterns in the last run (0..8)
//   err_vector  bit i set when pattern i mismatched
module adder_self_test #(
  parameter int unsigned STEP_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       stim_0,
  output logic       stim_1,
  output logic       stim_2,
  input  logic       led_0,
  input  logic       led_1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] err_vector
);

  localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state;
  logic [2:0]      pattern;
  logic [CntW-1:0] cnt;
  logic [2:0]      stim;
  logic [1:0]      led_q;

  logic exp_sum;
  logic exp_carry;
  logic mismatch;

  // Expected adder response to the pattern currently on the stim outputs.
  always_comb begin
    exp_sum   = pattern[0] ^ pattern[1] ^ pattern[2];
    exp_carry = (pattern[0] & pattern[1]) | (pattern[0] & pattern[2]) |
                (pattern[1] & pattern[2]);
    mismatch  = (led_q != {exp_carry, exp_sum});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      pattern    <= 3'd0;
      cnt        <= '0;
      stim       <= 3'b000;
      led_q      <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 4'd0;
      err_vector <= 8'h00;
    end else begin
      // Single sampling stage: the value judged on a compare edge was
      // produced by stim that had been stable for STEP_CYCLES-1 cycles.
      led_q <= {led_1, led_0};

      case (state)
        StIdle, StDone: begin
          if (start) begin
            state      <= StRun;
            pattern    <= 3'd0;
            cnt        <= '0;
            stim       <= 3'b000;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 4'd0;
            err_vector <= 8'h00;
          end
        end

        StRun: begin
          if (cnt == CntLast) begin
            if (mismatch) begin
              err_vector[pattern] <= 1'b1;
              err_count           <= err_count + 4'd1;
            end
            if (pattern != 3'd7) begin
              pattern <= pattern + 3'd1;
              stim    <= pattern + 3'd1;
              cnt     <= '0;
            end else begin
              // Last pattern: its own compare result feeds pass directly,
              // since err_count does not yet include it.
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
              stim  <= 3'b000;
              pass  <= ~mismatch && (err_count == 4'd0);
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign stim_0 = stim[0];
  assign stim_1 = stim[1];
  assign stim_2 = stim[2];

endmodule

// File: tb/tb_adder_self_test.sv
module tb_adder_self_test;

  localparam int unsigned Step = 4;

  typedef struct {
    int         fault;
    logic [7:0] ev;
    logic [3:0] ec;
    logic       ep;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stim_0, stim_1, stim_2;
  logic       led_0, led_1;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] err_vector;

  logic       start100;
  logic       s100_0, s100_1, s100_2;
  logic       l100_0, l100_1;
  logic       busy100, done100, pass100;
  logic [3:0] ec100;
  logic [7:0] ev100;

  int fault_mode;
  int n_checks;
  int n_fail;
  vec_t sb[$];
  vec_t vecs[3];

  adder_self_test #(.STEP_CYCLES(Step)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stim_0    (stim_0),
    .stim_1    (stim_1),
    .stim_2    (stim_2),
    .led_0     (led_0),
    .led_1     (led_1),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .err_vector(err_vector)
  );

  adder_self_test dut100 (
    .clk       (clk),
    .reset     (reset),
    .start     (start100),
    .stim_0    (s100_0),
    .stim_1    (s100_1),
    .stim_2    (s100_2),
    .led_0     (l100_0),
    .led_1     (l100_1),
    .busy      (busy100),
    .done      (done100),
    .pass      (pass100),
    .err_count (ec100),
    .err_vector(ev100)
  );

  // Adder models: fault 1 = carry stuck at 0, fault 2 = sum inverted.
  always_comb begin
    led_0  = (stim_0 ^ stim_1 ^ stim_2) ^ (fault_mode == 2);
    led_1  = (fault_mode == 1) ? 1'b0 :
             ((stim_0 & stim_1) | (stim_0 & stim_2) | (stim_1 & stim_2));
    l100_0 = s100_0 ^ s100_1 ^ s100_2;
    l100_1 = (s100_0 & s100_1) | (s100_0 & s100_2) | (s100_1 & s100_2);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stim"}, 32'({stim_2, stim_1, stim_0}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    chk({tag, "_err_vector"}, 32'(err_vector), 32'd0);
  endtask

  // One full run; the expected record is queued when start is driven and
  // compared when done is observed.
  task automatic run_one(input vec_t v, input bit hold);
    int   n;
    vec_t e;
    sb.push_back(v);
    fault_mode = v.fault;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (n < 32) begin
        chk("run_stim", 32'({stim_2, stim_1, stim_0}), 32'(n / Step));
        chk("run_busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      n++;
    end
    chk("done_latency", 32'(n), 32'd32);
    e = sb.pop_front();
    chk("done", 32'(done), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("stim_after", 32'({stim_2, stim_1, stim_0}), 32'd0);
    chk("pass", 32'(pass), 32'(e.ep));
    chk("err_count", 32'(err_count), 32'(e.ec));
    chk("err_vector", 32'(err_vector), 32'(e.ev));
  endtask

  initial begin
    int n;
    n_checks   = 0;
    n_fail     = 0;
    fault_mode = 0;
    start      = 1'b0;
    start100   = 1'b0;
    reset      = 1'b1;

    vecs[0] = '{fault: 0, ev: 8'h00, ec: 4'd0, ep: 1'b1};
    vecs[1] = '{fault: 1, ev: 8'hE8, ec: 4'd4, ep: 1'b0};
    vecs[2] = '{fault: 2, ev: 8'hFF, ec: 4'd8, ep: 1'b0};

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    for (int i = 0; i < 3; i++) run_one(vecs[i], 1'b0);

    // Start held high: exactly one run, then a restart from DONE.
    run_one(vecs[2], 1'b1);
    @(negedge clk);
    start = 1'b0;
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_err_count", 32'(err_count), 32'd0);
    chk("restart_err_vector", 32'(err_vector), 32'd0);
    chk("restart_stim", 32'({stim_2, stim_1, stim_0}), 32'd0);

    // Async reset while pattern 4 is on the outputs.
    n = 0;
    while ({stim_2, stim_1, stim_0} !== 3'b100 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_pattern4", 32'({stim_2, stim_1, stim_0}), 32'd4);
    #3 reset = 1'b1;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("post_reset");
    run_one(vecs[0], 1'b0);

    // Default step length on the second instance.
    @(negedge clk);
    start100 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start100 = 1'b0;
    n = 0;
    while (done100 !== 1'b1 && n < 900) begin
      if (n < 800) chk("stim100", 32'({s100_2, s100_1, s100_0}), 32'(n / 100));
      @(negedge clk);
      n++;
    end
    chk("done100_latency", 32'(n), 32'd800);
    chk("pass100", 32'(pass100), 32'd1);
    chk("busy100", 32'(busy100), 32'd0);
    chk("err_count100", 32'(ec100), 32'd0);
    chk("err_vector100", 32'(ev100), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
